load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_align.sv | 37 +++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 encodings, FSM state type and sizing helper for the LSU
// Revision: 1.0
// ============================================================================
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam int MEM_BYTES_DEFAULT = 8192;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RESP = 3'd4
   } lsu_state_t;

   // Access width in bytes; the unsigned variants share the low two bits.
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      logic [3:0] sz;
      case (funct3[1:0])
         2'b00:   sz = 4'd1;
         2'b01:   sz = 4'd2;
         2'b10:   sz = 4'd4;
         default: sz = 4'd8;
      endcase
      return sz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Selects the addressed lane of a doubleword and sign/zero-extends it
// Revision: 1.0
// ============================================================================
module load_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] i_dword,
   input  logic [2:0]      i_offset,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_result
);

   logic [XLEN-1:0] w_shifted;

   // Little-endian lanes: shifting right by the byte offset right-justifies the access.
   assign w_shifted = i_dword >> {i_offset, 3'b000};

   always_comb begin
      o_result = w_shifted;
      case (i_funct3)
         F3_B:    o_result = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
         F3_H:    o_result = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         F3_W:    o_result = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
         F3_BU:   o_result = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
         F3_HU:   o_result = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
         F3_WU:   o_result = {{(XLEN-32){1'b0}},          w_shifted[31:0]};
         default: o_result = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Single-outstanding load/store unit in front of a 64-bit data memory
// Revision: 1.0
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int XLEN      = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_writeData,
   output logic            mem_MemWrite,
   output logic            mem_MemRead,
   input  logic [XLEN-1:0] mem_readData
);

   localparam logic [XLEN-1:0] c_mem_limit = XLEN'(MEM_BYTES);

   lsu_state_t      r_state;
   logic            r_is_store;
   logic [2:0]      r_funct3;
   logic [2:0]      r_offset;
   logic [XLEN-1:0] r_wdata;
   logic            r_req_ready;
   logic            r_resp_valid;
   logic [XLEN-1:0] r_resp_rdata;
   logic            r_resp_fault;
   logic [XLEN-1:0] r_mem_address;
   logic [XLEN-1:0] r_mem_wdata;
   logic            r_mem_read;
   logic            r_mem_write;

   logic            w_bad_funct3;
   logic            w_misaligned;
   logic            w_out_of_range;
   logic            w_fault;
   logic            w_fire;
   logic [XLEN-1:0] w_aligned_addr;
   logic [3:0]      w_size;
   logic [7:0]      w_lane_mask;
   logic [XLEN-1:0] w_wdata_shifted;
   logic [XLEN-1:0] w_merged;
   logic [XLEN-1:0] w_load_data;

   // Acceptance-time checks, evaluated on the live request fields.
   always_comb begin
      w_bad_funct3 = (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
      case (req_funct3[1:0])
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         default: w_misaligned = |req_addr[2:0];
      endcase
   end

   assign w_out_of_range = (req_addr >= c_mem_limit);
   assign w_fault        = w_bad_funct3 || w_misaligned || w_out_of_range;
   assign w_fire         = req_valid && r_req_ready;
   assign w_aligned_addr = {req_addr[XLEN-1:3], 3'b000};

   // Read-modify-write merge: store bytes replace only the addressed lanes.
   assign w_size          = size_bytes(r_funct3);
   assign w_lane_mask     = 8'((16'd1 << w_size) - 16'd1) << r_offset;
   assign w_wdata_shifted = r_wdata << {r_offset, 3'b000};

   genvar k;
   generate
      for (k = 0; k < 8; k++) begin : g_merge_lane
         assign w_merged[8*k +: 8] = w_lane_mask[k] ? w_wdata_shifted[8*k +: 8]
                                                    : mem_readData[8*k +: 8];
      end
   endgenerate

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .i_dword  (mem_readData),
      .i_offset (r_offset),
      .i_funct3 (r_funct3),
      .o_result (w_load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_is_store    <= 1'b0;
         r_funct3      <= 3'b000;
         r_offset      <= 3'b000;
         r_wdata       <= '0;
         r_req_ready   <= 1'b1;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= '0;
         r_resp_fault  <= 1'b0;
         r_mem_address <= '0;
         r_mem_wdata   <= '0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire) begin
                  r_is_store  <= req_is_store;
                  r_funct3    <= req_funct3;
                  r_offset    <= req_addr[2:0];
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_fault <= 1'b1;
                     r_resp_rdata <= '0;
                  end else if (req_is_store && (req_funct3 == F3_D)) begin
                     // Full doubleword store needs no read of the old contents.
                     r_state       <= S_WR;
                     r_mem_write   <= 1'b1;
                     r_mem_address <= w_aligned_addr;
                     r_mem_wdata   <= req_wdata;
                  end else begin
                     r_state       <= S_RD;
                     r_mem_read    <= 1'b1;
                     r_mem_address <= w_aligned_addr;
                  end
               end
            end
            S_RD: begin
               r_mem_read <= 1'b0;
               r_state    <= S_CAP;
            end
            S_CAP: begin
               if (r_is_store) begin
                  r_state     <= S_WR;
                  r_mem_write <= 1'b1;
                  r_mem_wdata <= w_merged;
               end else begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_load_data;
                  r_resp_fault <= 1'b0;
               end
            end
            S_WR: begin
               r_mem_write  <= 1'b0;
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= '0;
               r_resp_fault <= 1'b0;
            end
            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
               r_mem_read   <= 1'b0;
               r_mem_write  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign resp_valid    = r_resp_valid;
   assign resp_rdata    = r_resp_rdata;
   assign resp_fault    = r_resp_fault;
   assign mem_address   = r_mem_address;
   assign mem_writeData = r_mem_wdata;
   assign mem_MemWrite  = r_mem_write;
   assign mem_MemRead   = r_mem_read;

endmodule
`default_nettype wire
